// File: rtl/tc77_responder.sv
// rtl/tc77_responder.sv - TC77-style SPI temperature sensor slave emulator
module tc77_responder #(
  parameter int          CONV_CYCLES = 24000,
  parameter logic [15:0] ID_WORD     = 16'h5400
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic [12:0] TEMP_VAL,
  input  logic        nCS,
  input  logic        SCK,
  input  logic        SIO_I,
  output logic        SIO_O,
  output logic        SIO_OE,
  output logic        SHUTDOWN
);

  localparam int          CW        = $clog2(CONV_CYCLES + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Three-stage chains: [0],[1] synchronize, [2] is the one-cycle-old copy for edge detect.
  logic [2:0]    cs_sync_q, cs_sync_d;
  logic [2:0]    sck_sync_q, sck_sync_d;
  logic [2:0]    sio_sync_q, sio_sync_d;

  state_t        state_q, state_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [12:0]   temp_q, temp_d;
  logic          flag_q, flag_d;
  logic          shutdown_q, shutdown_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   cfg_q, cfg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          sio_o_q, sio_o_d;
  logic          sio_oe_q, sio_oe_d;

  logic          cs_rise, cs_fall, sck_rise, sck_fall, sio_s;
  logic [15:0]   load_word, cfg_shift;

  assign cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];
  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];
  // Data sampled from the stage aligned with SCK just before its rising edge.
  assign sio_s    = sio_sync_q[2];

  assign load_word = shutdown_q ? ID_WORD : {temp_q, flag_q, 2'b00};
  assign cfg_shift = {cfg_q[14:0], sio_s};

  assign SIO_O    = sio_o_q;
  assign SIO_OE   = sio_oe_q;
  assign SHUTDOWN = shutdown_q;

  // Next-state logic: synchronizers, conversion timer, and the serial transaction FSM.
  always_comb begin
    cs_sync_d  = {cs_sync_q[1:0], nCS};
    sck_sync_d = {sck_sync_q[1:0], SCK};
    sio_sync_d = {sio_sync_q[1:0], SIO_I};
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    temp_d     = temp_q;
    flag_d     = flag_q;
    shutdown_d = shutdown_q;
    shift_d    = shift_q;
    cfg_d      = cfg_q;
    bit_cnt_d  = bit_cnt_q;
    sio_o_d    = sio_o_q;
    sio_oe_d   = sio_oe_q;

    // Conversion timer: free-running in continuous mode, parked at 0 in shutdown.
    if (shutdown_q) begin
      conv_cnt_d = '0;
    end else if (conv_cnt_q == CONV_LAST) begin
      conv_cnt_d = '0;
      temp_d     = TEMP_VAL;
      flag_d     = 1'b1;
    end else begin
      conv_cnt_d = conv_cnt_q + CW'(1);
    end

    // Chip-select release aborts whatever is in flight; a partial config is dropped.
    if (cs_rise) begin
      state_d   = ST_IDLE;
      sio_oe_d  = 1'b0;
      sio_o_d   = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            shift_d   = load_word;
            sio_o_d   = load_word[15];
            sio_oe_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_READ;
          end
        end
        ST_READ: begin
          if (sck_fall) begin
            // bit_cnt_q rises seen so far; this fall presents bit 15-bit_cnt_q.
            shift_d = {shift_q[14:0], 1'b0};
            sio_o_d = shift_q[14];
            if (bit_cnt_q >= 4'd14) begin
              sio_oe_d = 1'b0;
            end
          end else if (sck_rise) begin
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = '0;
              state_d   = ST_WRITE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_WRITE: begin
          sio_oe_d = 1'b0;
          if (sck_rise) begin
            cfg_d = cfg_shift;
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = '0;
              state_d   = ST_DONE;
              if (cfg_shift == 16'hFFFF) begin
                shutdown_d = 1'b1;
                flag_d     = 1'b0;
                conv_cnt_d = '0;
              end else if (cfg_shift == 16'h0000) begin
                shutdown_d = 1'b0;
                flag_d     = 1'b0;
                conv_cnt_d = '0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          // ST_DONE: SCK edges ignored until chip select is released.
        end
      endcase
    end
  end

  // State registers; nCS chain resets high so reset release never looks like a select.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      cs_sync_q  <= 3'b111;
      sck_sync_q <= 3'b000;
      sio_sync_q <= 3'b000;
      state_q    <= ST_IDLE;
      conv_cnt_q <= '0;
      temp_q     <= '0;
      flag_q     <= 1'b0;
      shutdown_q <= 1'b0;
      shift_q    <= '0;
      cfg_q      <= '0;
      bit_cnt_q  <= '0;
      sio_o_q    <= 1'b0;
      sio_oe_q   <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      sio_sync_q <= sio_sync_d;
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      temp_q     <= temp_d;
      flag_q     <= flag_d;
      shutdown_q <= shutdown_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      bit_cnt_q  <= bit_cnt_d;
      sio_o_q    <= sio_o_d;
      sio_oe_q   <= sio_oe_d;
    end
  end

endmodule

// File: tb/tb_tc77_responder.sv
// tb/tb_tc77_responder.sv - self-checking bench for tc77_responder
module tb_tc77_responder;

  localparam int CONV = 2000;
  localparam int H    = 5;

  logic        MCLK = 1'b0;
  logic        nRESET;
  logic [12:0] TEMP_VAL;
  logic        nCS, SCK, SIO_I;
  logic        SIO_O, SIO_OE, SHUTDOWN;

  int n_cmp = 0;
  int n_err = 0;

  tc77_responder #(.CONV_CYCLES(CONV), .ID_WORD(16'h5400)) dut (
    .MCLK(MCLK), .nRESET(nRESET), .TEMP_VAL(TEMP_VAL), .nCS(nCS), .SCK(SCK),
    .SIO_I(SIO_I), .SIO_O(SIO_O), .SIO_OE(SIO_OE), .SHUTDOWN(SHUTDOWN)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One master frame of nclk SCK periods; first 16 sampled, bits 16.. drive wr MSB first.
  task automatic run_frame(input logic [15:0] wr, input int nclk,
                           output logic [15:0] rd, output logic [15:0] oe);
    rd = '0;
    oe = '0;
    @(negedge MCLK);
    nCS = 1'b0;
    repeat (2*H) @(negedge MCLK);
    for (int i = 0; i < nclk; i++) begin
      if (i >= 16) SIO_I = wr[31-i];
      repeat (H) @(negedge MCLK);
      if (i < 16) begin
        rd[15-i] = SIO_O;
        oe[15-i] = SIO_OE;
      end
      SCK = 1'b1;
      repeat (H) @(negedge MCLK);
      SCK = 1'b0;
    end
    repeat (H) @(negedge MCLK);
    nCS = 1'b1;
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check("oe_after_cs_rise", {31'd0, SIO_OE}, 32'd0);
    repeat (H) @(negedge MCLK);
    SIO_I = 1'b0;
  endtask

  typedef struct {
    bit          do_wait;
    logic [12:0] temp;
    logic [15:0] wr;
    int          nclk;
    logic [15:0] exp_rd;
    bit          exp_shut;
  } vec_t;

  vec_t vecs[11];

  // Reference model state: mode, latched temperature, flag, restart bookkeeping.
  bit          m_shut, m_flag, m_pend;
  logic [12:0] m_lat;
  int          m_ops;

  function automatic logic [15:0] model_word();
    return m_shut ? 16'h5400 : {m_lat, m_flag, 2'b00};
  endfunction

  initial begin
    logic [15:0] rd, oe, wr;
    int          op, nclk;

    nRESET = 1'b0; nCS = 1'b1; SCK = 1'b0; SIO_I = 1'b0; TEMP_VAL = '0;
    repeat (5) @(posedge MCLK);
    @(negedge MCLK);
    check("reset_sio_o", {31'd0, SIO_O}, 32'd0);
    check("reset_sio_oe", {31'd0, SIO_OE}, 32'd0);
    check("reset_shutdown", {31'd0, SHUTDOWN}, 32'd0);
    nRESET = 1'b1;
    repeat (3) @(negedge MCLK);

    vecs[0]  = '{1'b0, 13'h0190, 16'h0000, 16, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 13'h0190, 16'h0000, 16, 16'h0C84, 1'b0};
    vecs[2]  = '{1'b0, 13'h0190, 16'hFFFF, 32, 16'h0C84, 1'b1};
    vecs[3]  = '{1'b0, 13'h0190, 16'h0000, 16, 16'h5400, 1'b1};
    vecs[4]  = '{1'b1, 13'h1F00, 16'h0000, 16, 16'h5400, 1'b1};
    vecs[5]  = '{1'b0, 13'h1F00, 16'h0000, 32, 16'h5400, 1'b0};
    vecs[6]  = '{1'b0, 13'h1F00, 16'h0000, 16, 16'h0C80, 1'b0};
    vecs[7]  = '{1'b1, 13'h1F00, 16'h0000, 16, 16'hF804, 1'b0};
    vecs[8]  = '{1'b0, 13'h1F00, 16'hFFFF, 20, 16'hF804, 1'b0};
    vecs[9]  = '{1'b0, 13'h1F00, 16'h1234, 32, 16'hF804, 1'b0};
    vecs[10] = '{1'b0, 13'h1F00, 16'h0000, 16, 16'hF804, 1'b0};

    for (int v = 0; v < 11; v++) begin
      TEMP_VAL = vecs[v].temp;
      if (vecs[v].do_wait) repeat (CONV + 50) @(negedge MCLK);
      run_frame(vecs[v].wr, vecs[v].nclk, rd, oe);
      check($sformatf("vec%0d_read", v), {16'd0, rd}, {16'd0, vecs[v].exp_rd});
      check($sformatf("vec%0d_oe", v), {16'd0, oe}, 32'h0000FFFC);
      check($sformatf("vec%0d_shutdown", v), {31'd0, SHUTDOWN}, {31'd0, vecs[v].exp_shut});
    end

    // Reset in the middle of a read, while bit 7 (a one) is on the wire.
    TEMP_VAL = 13'h0055;
    repeat (CONV + 50) @(negedge MCLK);
    nCS = 1'b0;
    repeat (2*H) @(negedge MCLK);
    for (int i = 0; i < 8; i++) begin
      repeat (H) @(negedge MCLK);
      SCK = 1'b1;
      repeat (H) @(negedge MCLK);
      SCK = 1'b0;
    end
    repeat (H) @(negedge MCLK);
    check("bit7_sio_o", {31'd0, SIO_O}, 32'd1);
    check("bit7_sio_oe", {31'd0, SIO_OE}, 32'd1);
    nRESET = 1'b0;
    #1;
    check("midreset_sio_o", {31'd0, SIO_O}, 32'd0);
    check("midreset_sio_oe", {31'd0, SIO_OE}, 32'd0);
    nCS = 1'b1;
    repeat (3) @(negedge MCLK);
    nRESET = 1'b1;
    repeat (3) @(negedge MCLK);
    run_frame(16'h0000, 16, rd, oe);
    check("post_reset_read", {16'd0, rd}, 32'h00000000);
    check("post_reset_oe", {16'd0, oe}, 32'h0000FFFC);

    // Randomized operations against the mode/flag/temperature model.
    m_shut = 1'b0; m_flag = 1'b0; m_lat = '0; m_pend = 1'b1; m_ops = 1;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 19);
      if (m_pend && m_ops >= 3) op = 0;
      if (op < 4) begin
        TEMP_VAL = 13'($urandom);
        repeat (CONV + 50) @(negedge MCLK);
        if (!m_shut) begin
          m_lat  = TEMP_VAL;
          m_flag = 1'b1;
          m_pend = 1'b0;
        end
        continue;
      end
      if (op < 11)      begin wr = 16'h0000; nclk = 16; end
      else if (op < 14) begin wr = 16'hFFFF; nclk = 32; end
      else if (op < 17) begin wr = 16'h0000; nclk = 32; end
      else if (op < 19) begin
        wr = 16'($urandom);
        if (wr == 16'h0000 || wr == 16'hFFFF) wr = 16'h1234;
        nclk = 32;
      end else begin
        wr = 16'($urandom);
        nclk = $urandom_range(17, 31);
      end
      run_frame(wr, nclk, rd, oe);
      check($sformatf("rnd%0d_read", n), {16'd0, rd}, {16'd0, model_word()});
      check($sformatf("rnd%0d_oe", n), {16'd0, oe}, 32'h0000FFFC);
      m_ops++;
      if (nclk == 32 && wr == 16'hFFFF) begin
        m_shut = 1'b1;
        m_flag = 1'b0;
      end else if (nclk == 32 && wr == 16'h0000) begin
        m_shut = 1'b0;
        m_flag = 1'b0;
        m_pend = 1'b1;
        m_ops  = 0;
      end
      check($sformatf("rnd%0d_shutdown", n), {31'd0, SHUTDOWN}, {31'd0, m_shut});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
